i2s_pcm_receiver: RTL

Single-clock I2S receiver that deserializes a stereo I2S stream (bit clock, word select, serial data) into parallel left/right PCM words with a valid/ready handshake. It is the reading end of the beamformed I2S output produced by the supermic top. It serves as an on-chip loopback checker and as the capture front end for a downstream consumer. All I2S inputs are asynchronous to `clk` and are oversampled.

---
 rtl/i2s_pcm_receiver_if.sv | 26 ++
 rtl/i2s_pcm_receiver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_pcm_receiver_if.sv
// PCM frame handshake bundle between the I2S receiver and its consumer.
// The receiver drives the stereo word pair and out_valid; the consumer
// answers with out_ready.
`timescale 1ns/1ps
interface i2s_pcm_receiver_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] left_data;
   logic [WIDTH-1:0] right_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output left_data,
      output right_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  left_data,
      input  right_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/i2s_pcm_receiver.sv
// Oversampling I2S receiver. It synchronises sck/ws/sd into clk and advances
// on each sck rising edge. Each slot is deserialised left-justified; bits
// beyond WIDTH are truncated and missing LSBs are zero-filled. Complete
// left+right pairs are handed out over a valid/ready bundle. A frame that
// arrives while the previous one is still unaccepted is dropped and flagged.
`timescale 1ns/1ps
module i2s_pcm_receiver #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sck_i,
   input  logic                   ws_i,
   input  logic                   sd_i,
   i2s_pcm_receiver_if.master     pcm,
   output logic                   short_err_o,
   output logic                   overrun_o
);

   typedef enum logic [1:0] {
      ST_UNSYNC = 2'd0,
      ST_LEFT   = 2'd1,
      ST_RIGHT  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
   localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

   // synchroniser chain: sck gets a third stage for rising-edge detection
   logic sck_s1_q, sck_s2_q, sck_s3_q;
   logic ws_s1_q, ws_s2_q;
   logic sd_s1_q, sd_s2_q;

   state_e           state_q, state_d;
   logic             ws_prev_q, ws_prev_d;
   logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] left_hold_q, left_hold_d;
   logic [WIDTH-1:0] left_data_q, left_data_d;
   logic [WIDTH-1:0] right_data_q, right_data_d;
   logic             out_valid_q, out_valid_d;
   logic             short_err_q, short_err_d;
   logic             overrun_q, overrun_d;

   logic             rise_s;
   logic             boundary_s;
   logic             append_s;
   logic             short_s;
   logic             frame_s;
   logic             load_s;
   logic [WIDTH-1:0] mask_s;
   logic [WIDTH-1:0] word_s;

   // bring the asynchronous I2S lines into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_s1_q <= 1'b0;
         sck_s2_q <= 1'b0;
         sck_s3_q <= 1'b0;
         ws_s1_q  <= 1'b0;
         ws_s2_q  <= 1'b0;
         sd_s1_q  <= 1'b0;
         sd_s2_q  <= 1'b0;
      end else begin
         sck_s1_q <= sck_i;
         sck_s2_q <= sck_s1_q;
         sck_s3_q <= sck_s2_q;
         ws_s1_q  <= ws_i;
         ws_s2_q  <= ws_s1_q;
         sd_s1_q  <= sd_i;
         sd_s2_q  <= sd_s1_q;
      end
   end

   // bit-level datapath: edge detect, append the sampled bit, slot bookkeeping
   always_comb begin
      rise_s     = sck_s2_q & ~sck_s3_q;
      boundary_s = rise_s & (ws_s2_q != ws_prev_q);
      append_s   = (bitcnt_q < WIDTH_C);
      // bit position of the next data bit, counted down from the MSB
      mask_s     = TOP_BIT >> bitcnt_q;
      if (append_s) begin
         word_s = shreg_q | (mask_s & {WIDTH{sd_s2_q}});
      end else begin
         word_s = shreg_q;
      end
      // the bit appended at the boundary brings the count to bitcnt_q + 1
      short_s    = (bitcnt_q < (WIDTH_C - CNT_W'(1)));

      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;
      ws_prev_d = ws_prev_q;
      if (boundary_s) begin
         shreg_d   = '0;
         bitcnt_d  = '0;
         ws_prev_d = ws_s2_q;
      end else if (rise_s && append_s) begin
         shreg_d   = word_s;
         bitcnt_d  = bitcnt_q + CNT_W'(1);
      end else begin
         shreg_d   = shreg_q;
         bitcnt_d  = bitcnt_q;
      end
   end

   // slot sequencing FSM: next state, left hold capture, frame and short flags
   always_comb begin
      state_d     = state_q;
      left_hold_d = left_hold_q;
      frame_s     = 1'b0;
      short_err_d = 1'b0;
      case (state_q)
         ST_UNSYNC: begin
            if (boundary_s && !ws_s2_q && ws_prev_q) begin
               state_d = ST_LEFT;
            end else begin
               state_d = ST_UNSYNC;
            end
         end
         ST_LEFT: begin
            if (boundary_s) begin
               short_err_d = short_s;
               if (ws_s2_q) begin
                  left_hold_d = word_s;
                  state_d     = ST_RIGHT;
               end else begin
                  state_d     = ST_LEFT;
               end
            end else begin
               state_d = ST_LEFT;
            end
         end
         ST_RIGHT: begin
            if (boundary_s) begin
               short_err_d = short_s;
               if (!ws_s2_q) begin
                  frame_s = 1'b1;
                  state_d = ST_LEFT;
               end else begin
                  state_d = ST_RIGHT;
               end
            end else begin
               state_d = ST_RIGHT;
            end
         end
         default: begin
            state_d = ST_UNSYNC;
         end
      endcase
   end

   // frame delivery: load when the output slot is free or being accepted now
   always_comb begin
      load_s       = frame_s & (~out_valid_q | pcm.out_ready);
      overrun_d    = frame_s & ~load_s;
      left_data_d  = left_data_q;
      right_data_d = right_data_q;
      out_valid_d  = out_valid_q;
      if (load_s) begin
         left_data_d  = left_hold_q;
         right_data_d = word_s;
         out_valid_d  = 1'b1;
      end else if (pcm.out_ready) begin
         out_valid_d  = 1'b0;
      end else begin
         out_valid_d  = out_valid_q;
      end
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_UNSYNC;
         ws_prev_q    <= 1'b0;
         bitcnt_q     <= '0;
         shreg_q      <= '0;
         left_hold_q  <= '0;
         left_data_q  <= '0;
         right_data_q <= '0;
         out_valid_q  <= 1'b0;
         short_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ws_prev_q    <= ws_prev_d;
         bitcnt_q     <= bitcnt_d;
         shreg_q      <= shreg_d;
         left_hold_q  <= left_hold_d;
         left_data_q  <= left_data_d;
         right_data_q <= right_data_d;
         out_valid_q  <= out_valid_d;
         short_err_q  <= short_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign pcm.left_data  = left_data_q;
   assign pcm.right_data = right_data_q;
   assign pcm.out_valid  = out_valid_q;
   assign short_err_o    = short_err_q;
   assign overrun_o      = overrun_q;

endmodule
